// File: rtl/prvp_spi_slave_ctrl.sv
// SPI slave frame sequencer: decodes the opening command, captures the start address, then emits one write per data word.
// Strobes are combinational in the chunk-completion cycle; flags/counters register on that edge. fifo_full drops the word but never stalls.
module prvp_spi_slave_ctrl #(
  parameter logic [7:0]  CMD_WR_SINGLE = 8'h02,
  parameter logic [7:0]  CMD_WR_QUAD   = 8'h32,
  parameter int unsigned ADDR_INC      = 4
) (
  input  logic        clk,
  input  logic        rstnn,
  input  logic [31:0] rx_data,
  input  logic        rx_ready,
  input  logic        fifo_full,
  output logic [7:0]  cnt_trgt,
  output logic        cnt_trgt_upd,
  output logic        en_quad,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  output logic [15:0] word_cnt,
  output logic        err_cmd,
  output logic        err_overflow
);

  typedef enum logic [1:0] {ST_CMD, ST_ADDR, ST_DATA, ST_IGNORE} state_e;

  state_e      state_q, state_d;
  logic        en_quad_q, en_quad_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        err_cmd_q, err_cmd_d;
  logic        err_ovf_q, err_ovf_d;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q    <= ST_CMD;
      en_quad_q  <= 1'b0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      err_cmd_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_quad_q  <= en_quad_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      err_cmd_q  <= err_cmd_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Strobes must settle before the edge that completes the chunk, so the
  // final word of a frame is written before chip select releases.
  always_comb begin
    state_d      = state_q;
    en_quad_d    = en_quad_q;
    addr_d       = addr_q;
    word_cnt_d   = word_cnt_q;
    err_cmd_d    = err_cmd_q;
    err_ovf_d    = err_ovf_q;
    cnt_trgt     = '0;
    cnt_trgt_upd = 1'b0;
    wr_valid     = 1'b0;
    wr_data      = '0;
    case (state_q)
      ST_CMD: begin
        if (rx_ready) begin
          if (rx_data[7:0] == CMD_WR_SINGLE) begin
            cnt_trgt     = 8'd31;
            cnt_trgt_upd = 1'b1;
            state_d      = ST_ADDR;
          end else if (rx_data[7:0] == CMD_WR_QUAD) begin
            cnt_trgt     = 8'd7;
            cnt_trgt_upd = 1'b1;
            en_quad_d    = 1'b1;
            state_d      = ST_ADDR;
          end else begin
            err_cmd_d = 1'b1;
            state_d   = ST_IGNORE;
          end
        end
      end
      ST_ADDR: begin
        if (rx_ready) begin
          addr_d  = rx_data;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_ready) begin
          wr_valid = 1'b1;
          wr_data  = rx_data;
          addr_d   = addr_q + 32'(ADDR_INC);
          if (fifo_full) begin
            err_ovf_d = 1'b1;
          end else if (word_cnt_q != 16'hFFFF) begin
            word_cnt_d = word_cnt_q + 16'd1;
          end
        end
      end
      ST_IGNORE: ;
      default: state_d = ST_IGNORE;
    endcase
  end

  assign en_quad      = en_quad_q;
  assign wr_addr      = addr_q;
  assign word_cnt     = word_cnt_q;
  assign err_cmd      = err_cmd_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_prvp_spi_slave_ctrl.sv
// Frame-level bench: emulates the receive shifter's chunk timing and predicts every output from frame contents.
module tb_prvp_spi_slave_ctrl;

  logic        clk;
  logic        rstnn;
  logic [31:0] rx_data;
  logic        rx_ready;
  logic        fifo_full;
  logic [7:0]  cnt_trgt;
  logic        cnt_trgt_upd;
  logic        en_quad;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic [15:0] word_cnt;
  logic        err_cmd;
  logic        err_overflow;

  prvp_spi_slave_ctrl dut (
    .clk(clk), .rstnn(rstnn), .rx_data(rx_data), .rx_ready(rx_ready),
    .fifo_full(fifo_full), .cnt_trgt(cnt_trgt), .cnt_trgt_upd(cnt_trgt_upd),
    .en_quad(en_quad), .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
    .word_cnt(word_cnt), .err_cmd(err_cmd), .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected outputs for the current cycle
  logic [31:0] e_upd, e_trgt, e_quad, e_waddr, e_wdata, e_wv, e_cnt, e_errc, e_erro;
  bit          chk_en = 0;
  int          cyc = 0;

  // Per-frame observations used by the literal pins
  int          npulse, nupd, upd_clk;
  int          pclk[8];
  logic [31:0] paddr[8];
  logic [31:0] upd_trgt;
  bit          quad_seen;

  logic [31:0] wq[$];
  bit          fq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t cyc=%0d: got %h want %h", nm, $time, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("cnt_trgt_upd", 32'(cnt_trgt_upd), e_upd);
      chk("cnt_trgt",     32'(cnt_trgt),     e_trgt);
      chk("en_quad",      32'(en_quad),      e_quad);
      chk("wr_addr",      wr_addr,           e_waddr);
      chk("wr_data",      wr_data,           e_wdata);
      chk("wr_valid",     32'(wr_valid),     e_wv);
      chk("word_cnt",     32'(word_cnt),     e_cnt);
      chk("err_cmd",      32'(err_cmd),      e_errc);
      chk("err_overflow", 32'(err_overflow), e_erro);
      if (wr_valid === 1'b1) begin
        if (npulse < 8) begin
          pclk[npulse]  = cyc;
          paddr[npulse] = wr_addr;
        end
        npulse++;
      end
      if (cnt_trgt_upd === 1'b1) begin
        nupd++;
        upd_clk  = cyc;
        upd_trgt = 32'(cnt_trgt);
      end
      if (en_quad === 1'b1) quad_seen = 1;
    end
  end

  task automatic do_reset();
    rstnn = 1'b0;
    cyc   = 0;
    {e_upd, e_trgt, e_quad, e_waddr, e_wdata, e_wv, e_cnt, e_errc, e_erro} = '0;
    chk_en = 1;
    for (int i = 0; i < 2; i++) begin
      rx_ready  = 1'b0;
      rx_data   = $urandom;
      fifo_full = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rstnn = 1'b1;
  endtask

  // One chip-select frame; clock abort_clk (if nonzero) is replaced by reset.
  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] base, input int abort_clk);
    bit known, quad;
    int len, nw, tot, done, acc;
    bit ovf;
    logic [31:0] tmp;
    known = (cmd == 8'h02) || (cmd == 8'h32);
    quad  = (cmd == 8'h32);
    nw    = wq.size();
    len   = (known && !quad) ? 32 : 8;
    tot   = known ? 8 + len * (1 + nw) : 8 + 64;
    done  = 0; acc = 0; ovf = 0;
    npulse = 0; nupd = 0; upd_clk = 0; upd_trgt = '0; quad_seen = 0;
    for (int c = 1; c <= tot + 1; c++) begin
      int k;
      if (c == abort_clk) return;
      k = -1;
      if (c == 8) k = 0;
      else if (c > 8 && c <= tot && (c - 8) % len == 0) k = (c - 8) / len;
      cyc     = c;
      e_quad  = 32'(quad && c > 8);
      e_errc  = 32'(!known && c > 8);
      e_cnt   = 32'(acc);
      e_erro  = 32'(ovf);
      e_waddr = (known && c > 8 + len) ? base + 32'(4 * done) : 32'h0;
      rx_ready = (k >= 0);
      tmp = $urandom;
      if (k == 0)                rx_data = {tmp[31:8], cmd};
      else if (k == 1)           rx_data = base;
      else if (k >= 2 && known)  rx_data = wq[k-2];
      else                       rx_data = tmp;
      fifo_full = (known && k >= 2) ? fq[k-2] : 1'($urandom_range(0, 1));
      e_upd   = 32'(known && k == 0);
      e_trgt  = (known && k == 0) ? (quad ? 32'd7 : 32'd31) : 32'd0;
      e_wv    = 32'(known && k >= 2);
      e_wdata = (known && k >= 2) ? wq[k-2] : 32'h0;
      @(negedge clk);
      if (known && k >= 2) begin
        done++;
        if (fq[k-2]) ovf = 1;
        else acc++;
      end
    end
  endtask

  initial begin
    int nw, ab, tot;
    logic [7:0] cmd;
    rstnn = 1'b0; rx_ready = 1'b0; rx_data = '0; fifo_full = 1'b0;
    {e_upd, e_trgt, e_quad, e_waddr, e_wdata, e_wv, e_cnt, e_errc, e_erro} = '0;
    @(negedge clk);

    // Quad write, two words
    do_reset();
    wq = '{32'hDEADBEEF, 32'h01234567}; fq = '{0, 0};
    run_frame(8'h32, 32'h1000_0000, 0);
    chk("quad_upd_clk", 32'(upd_clk), 32'd8);
    chk("quad_upd_trgt", upd_trgt, 32'd7);
    chk("quad_npulse", 32'(npulse), 32'd2);
    chk("quad_p0_clk", 32'(pclk[0]), 32'd24);
    chk("quad_p1_clk", 32'(pclk[1]), 32'd32);
    chk("quad_p0_addr", paddr[0], 32'h1000_0000);
    chk("quad_p1_addr", paddr[1], 32'h1000_0004);
    chk("quad_word_cnt", 32'(word_cnt), 32'd2);

    // Single write, one word
    do_reset();
    wq = '{32'hA5A5_5A5A}; fq = '{0};
    run_frame(8'h02, 32'h0000_0040, 0);
    chk("single_upd_trgt", upd_trgt, 32'd31);
    chk("single_quad_seen", 32'(quad_seen), 32'd0);
    chk("single_npulse", 32'(npulse), 32'd1);
    chk("single_p0_clk", 32'(pclk[0]), 32'd72);
    chk("single_p0_addr", paddr[0], 32'h0000_0040);

    // Unknown command
    do_reset();
    wq = '{}; fq = '{};
    run_frame(8'hFF, 32'h0, 0);
    chk("unk_err_cmd", 32'(err_cmd), 32'd1);
    chk("unk_nupd", 32'(nupd), 32'd0);
    chk("unk_npulse", 32'(npulse), 32'd0);

    // Address wrap
    do_reset();
    wq = '{32'h1111_1111, 32'h2222_2222}; fq = '{0, 0};
    run_frame(8'h32, 32'hFFFF_FFFC, 0);
    chk("wrap_p0_addr", paddr[0], 32'hFFFF_FFFC);
    chk("wrap_p1_addr", paddr[1], 32'h0000_0000);

    // FIFO full on the middle word
    do_reset();
    wq = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003}; fq = '{0, 1, 0};
    run_frame(8'h32, 32'h2000_0100, 0);
    chk("full_npulse", 32'(npulse), 32'd3);
    chk("full_err_ovf", 32'(err_overflow), 32'd1);
    chk("full_word_cnt", 32'(word_cnt), 32'd2);
    chk("full_p2_addr", paddr[2], 32'h2000_0108);

    // Abort at clock 20, then a fresh single frame
    do_reset();
    wq = '{32'hBAD0_BAD0}; fq = '{0};
    run_frame(8'h32, 32'h3000_0000, 20);
    chk("abort_npulse", 32'(npulse), 32'd0);
    do_reset();
    wq = '{32'h0BAD_F00D}; fq = '{0};
    run_frame(8'h02, 32'h0000_0800, 0);
    chk("after_abort_quad_seen", 32'(quad_seen), 32'd0);
    chk("after_abort_npulse", 32'(npulse), 32'd1);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: cmd = 8'h32;
        5, 6, 7:       cmd = 8'h02;
        default:       cmd = 8'($urandom);
      endcase
      nw = (cmd == 8'h02) ? $urandom_range(0, 2) : $urandom_range(0, 5);
      wq = '{}; fq = '{};
      for (int i = 0; i < nw; i++) begin
        wq.push_back($urandom);
        fq.push_back($urandom_range(0, 3) == 0);
      end
      tot = (cmd == 8'h02) ? 8 + 32 * (1 + nw) : 8 + 8 * (1 + nw);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot) : 0;
      do_reset();
      run_frame(cmd, $urandom, ab);
    end

    do_reset();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
